// File: rtl/branch_predictor_if.sv
// Lookup/update/status bundle between the core pipeline and the branch predictor.
// Lookup results are combinational on lk_pc; update fields are sampled on the clock edge.
// No back-pressure: every update presented with upd_valid is taken.
interface branch_predictor_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;
  logic            tbl_clear;
  logic [31:0]     mispred_cnt;
  logic [31:0]     upd_cnt;

  // Core side: drives lookup PC and resolved-branch training.
  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, tbl_clear,
    input  pred_hit, pred_taken, pred_target, mispred_cnt, upd_cnt
  );

  // Predictor side.
  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, tbl_clear,
    output pred_hit, pred_taken, pred_target, mispred_cnt, upd_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters for next-PC prediction.
// Lookup is 0 cycles (combinational on registered state); updates visible the next cycle.
// No back-pressure: updates are always accepted, tbl_clear wins over a same-cycle update.
module branch_predictor #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic           clk,
  input  logic           reset,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [XLEN-1:0]   target_d [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_d    [ENTRIES];
  logic [31:0]       upd_cnt_q, upd_cnt_d;
  logic [31:0]       mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              upd_hit;
  logic              unused_pc_bits;

  assign lk_idx  = bp.lk_pc[IDX_W+1:2];
  assign lk_tag  = bp.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = bp.upd_pc[IDX_W+1:2];
  assign upd_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // PC bits outside index/tag do not participate in prediction.
  assign unused_pc_bits = ^{bp.lk_pc[XLEN-1:IDX_W+TAG_W+2], bp.lk_pc[1:0],
                            bp.upd_pc[XLEN-1:IDX_W+TAG_W+2], bp.upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign bp.pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign bp.pred_taken  = bp.pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign bp.pred_target = bp.pred_hit ? target_q[lk_idx] : '0;
  assign bp.upd_cnt     = upd_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

  // Table training: clear beats update; hits train the counter, taken misses allocate.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bp.tbl_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_WNT;
      end
    end else if (bp.upd_valid) begin
      if (upd_hit) begin
        if (bp.upd_taken) begin
          if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
          target_d[upd_idx] = bp.upd_target;
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (bp.upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bp.upd_target;
        ctr_d[upd_idx]    = CTR_WT;
      end
    end
  end

  // Statistics counters count every update, independent of clear, and saturate.
  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.upd_valid && (upd_cnt_q != 32'hFFFF_FFFF)) upd_cnt_d = upd_cnt_q + 32'd1;
    if (bp.upd_valid && bp.upd_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      upd_cnt_q     <= upd_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined RISC-V core: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. It is looked up combinationally from the IF-stage PC, giving a predicted next-PC for the PC-source mux. It is trained from the MEM-stage branch-resolution point, where `Branch_Control` decides taken/not-taken. The core currently resolves every branch as predict-not-taken with a flush; this block replaces that behaviour.

## Interface
Parameters:
- XLEN, 64, PC and target width.
- ENTRIES, 16, BTB entries; power of two, ≥ 2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- CTR_W, 2, direction counter width; ≥ 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- lk_pc  input  XLEN  IF-stage PC to look up.
- pred_hit  output  1  valid entry with matching tag.
- pred_taken  output  1  predict taken.
- pred_target  output  XLEN  stored target; 0 when pred_hit=0.
- upd_valid  input  1  resolved branch present this cycle.
- upd_pc  input  XLEN  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  XLEN  actual target (PC+imm).
- upd_mispredict  input  1  pipeline flushed for this branch; qualified by upd_valid.
- tbl_clear  input  1  synchronous invalidate of all entries.
- mispred_cnt  output  32  saturating mispredict counter.
- upd_cnt  output  32  saturating count of accepted updates.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. The same slicing applies to lk_pc and upd_pc.
- Per entry: valid (1), tag (TAG_W), target (XLEN), ctr (CTR_W).
- Lookup is purely combinational from registered state:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr[CTR_W-1].
  - pred_target = pred_hit ? target : 0.
- Update (upd_valid=1, tbl_clear=0):
  - Hit, taken: ctr saturating +1 (max 2^CTR_W−1); target ← upd_target.
  - Hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - Miss, taken: allocate/replace the entry. valid←1, tag←upd tag, target←upd_target, ctr←2^(CTR_W−1) (weakly taken).
  - Miss, not taken: no state change.
- upd_cnt increments on every upd_valid=1 cycle. mispred_cnt increments when upd_valid & upd_mispredict. Both saturate at 0xFFFF_FFFF.
- tbl_clear=1: all valid←0 and ctr←2^(CTR_W−1)−1 (weakly not-taken; 0 when CTR_W=1). Tags and targets are don't-care. Counters upd_cnt/mispred_cnt are not cleared.
- tbl_clear and upd_valid in the same cycle: the clear wins and the table update is dropped. upd_cnt and mispred_cnt still count.

## Timing
- reset low (asynchronous, immediate): every valid=0, ctr=2^(CTR_W−1)−1, tag=0, target=0, upd_cnt=0, mispred_cnt=0.
  - Consequently pred_hit=0, pred_taken=0, pred_target=0 throughout reset.
- Lookup latency is 0 cycles (combinational).
- An update in cycle N is visible to lookup from cycle N+1.
- Same-cycle lookup and update to the same index: lookup returns pre-update state. There is no bypass.
- Reset deasserted mid-stream: the first edge after deassertion may perform an update. Behaviour is as from the reset state.
- No handshake: updates are always accepted; there is no back-pressure.

## Test plan
- Reset: assert reset=0 mid-run after populating the table. Outputs immediately go to 0; lookup of any PC gives pred_hit=0. Both counters read 0.
- Allocation: update pc=0x100, taken, target=0x200. Next cycle, lookup 0x100 gives hit=1, taken=1, target=0x200. Lookup 0x104 gives hit=0.
- Saturation (CTR_W=2): after allocation, 2 not-taken updates give taken=0. A 3rd not-taken leaves ctr=0. Then 2 taken updates give taken=1, and further taken updates leave ctr=3.
- Aliasing/tag: with ENTRIES=16, allocate 0x100 then update 0x140 (same index, different tag) taken→0x300. Lookup 0x100 gives hit=0; lookup 0x140 gives target=0x300.
- Miss not-taken: update an unallocated PC not-taken. The next lookup of that PC gives hit=0, and upd_cnt increments by 1.
- Clear vs update: in the same cycle, tbl_clear=1 and upd_valid=1 taken with upd_mispredict=1. Next cycle all lookups give hit=0, upd_cnt+1, mispred_cnt+1.
